// File: rtl/hyper_cordic_iter_pkg.sv
// Shared constants for the iterative hyperbolic CORDIC engine: widths, FSM states,
// the atanh(2^-i) table and the indices that hyperbolic convergence requires to be run twice.
package hyper_cordic_iter_pkg;

  localparam int I_INT_WIDTH = 4;
  localparam int I_FRA_WIDTH = 16;
  localparam int IDWIDTH     = 1 + I_INT_WIDTH + I_FRA_WIDTH;
  localparam int IDX_W       = 6;

  localparam logic [IDX_W-1:0] IDX_FIRST  = 6'd3;
  localparam logic [IDX_W-1:0] IDX_MAX    = 6'd39;
  localparam logic [IDX_W-1:0] REP_IDX_LO = 6'd4;
  localparam logic [IDX_W-1:0] REP_IDX_HI = 6'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // round(atanh(2^-i) * 2^16) for i = 3..39; entries past 17 round to zero
  localparam logic [IDWIDTH-1:0] ATANH_LUT [3:39] = '{
    21'd8235, 21'd4101, 21'd2049, 21'd1024, 21'd512, 21'd256, 21'd128,
    21'd64,   21'd32,   21'd16,   21'd8,    21'd4,   21'd2,   21'd1,
    21'd1,    21'd0,    21'd0,    21'd0,    21'd0,   21'd0,   21'd0,
    21'd0,    21'd0,    21'd0,    21'd0,    21'd0,   21'd0,   21'd0,
    21'd0,    21'd0,    21'd0,    21'd0,    21'd0,   21'd0,   21'd0,
    21'd0,    21'd0
  };

  function automatic logic is_rep_idx(input logic [IDX_W-1:0] idx);
    return (idx == REP_IDX_LO) || (idx == REP_IDX_HI);
  endfunction

endpackage

// File: rtl/fixedAddSub.sv
// Signed fixed-point adder/subtractor (MODE 0 add, MODE 1 sub) with overflow flag
// and optional saturation to the most positive / most negative word.
module fixedAddSub #(
  parameter int WIDTH = 21,
  parameter int MODE  = 0,
  parameter bit SAT   = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  logic [WIDTH:0] ext_s;

  always_comb begin
    if (MODE == 0) begin
      ext_s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    end else begin
      ext_s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    end
    ovf = ext_s[WIDTH] ^ ext_s[WIDTH-1];
    if (SAT && ovf) begin
      y = ext_s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      y = ext_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/hyper_cordic_microrot.sv
// One combinational hyperbolic micro-rotation at shift index idx.
// HYPER_CORDIC_SAT_EN selects saturating arithmetic and adds the ovf output.
module hyper_cordic_microrot
  import hyper_cordic_iter_pkg::*;
#(
  parameter int DWIDTH = IDWIDTH
) (
  input  logic [DWIDTH-1:0] x,
  input  logic [DWIDTH-1:0] y,
  input  logic [DWIDTH-1:0] z,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DWIDTH-1:0] lut,
  output logic [DWIDTH-1:0] x_nxt,
  output logic [DWIDTH-1:0] y_nxt,
  output logic [DWIDTH-1:0] z_nxt
`ifdef HYPER_CORDIC_SAT_EN
  ,
  output logic              ovf
`endif
);

`ifdef HYPER_CORDIC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic              d_pos;
  logic [DWIDTH-1:0] x_sh, y_sh;
  logic [DWIDTH-1:0] x_add, x_sub, y_add, y_sub, z_add, z_sub;
  logic              x_add_ovf, x_sub_ovf, y_add_ovf, y_sub_ovf, z_add_ovf, z_sub_ovf;
  logic              ovf_sel;

  // d = +1 when z is non-negative; shifts floor toward minus infinity
  assign d_pos = ~z[DWIDTH-1];
  assign x_sh  = $signed(x) >>> idx;
  assign y_sh  = $signed(y) >>> idx;

  fixedAddSub #(.WIDTH(DWIDTH), .MODE(0), .SAT(SAT_EN)) u_x_add (.a(x), .b(y_sh), .y(x_add), .ovf(x_add_ovf));
  fixedAddSub #(.WIDTH(DWIDTH), .MODE(1), .SAT(SAT_EN)) u_x_sub (.a(x), .b(y_sh), .y(x_sub), .ovf(x_sub_ovf));
  fixedAddSub #(.WIDTH(DWIDTH), .MODE(0), .SAT(SAT_EN)) u_y_add (.a(y), .b(x_sh), .y(y_add), .ovf(y_add_ovf));
  fixedAddSub #(.WIDTH(DWIDTH), .MODE(1), .SAT(SAT_EN)) u_y_sub (.a(y), .b(x_sh), .y(y_sub), .ovf(y_sub_ovf));
  fixedAddSub #(.WIDTH(DWIDTH), .MODE(0), .SAT(SAT_EN)) u_z_add (.a(z), .b(lut),  .y(z_add), .ovf(z_add_ovf));
  fixedAddSub #(.WIDTH(DWIDTH), .MODE(1), .SAT(SAT_EN)) u_z_sub (.a(z), .b(lut),  .y(z_sub), .ovf(z_sub_ovf));

  assign x_nxt   = d_pos ? x_add : x_sub;
  assign y_nxt   = d_pos ? y_add : y_sub;
  assign z_nxt   = d_pos ? z_sub : z_add;
  assign ovf_sel = d_pos ? (x_add_ovf | y_add_ovf | z_sub_ovf)
                         : (x_sub_ovf | y_sub_ovf | z_add_ovf);

`ifdef HYPER_CORDIC_SAT_EN
  assign ovf = ovf_sel;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_sel;
`endif

endmodule

// File: rtl/hyper_cordic_iter.sv
// Iterative hyperbolic CORDIC: runs micro-rotations 3..N_ITER (4 and 13 twice) on one shared datapath.
// Define HYPER_CORDIC_SAT_EN for saturating add/sub and the sticky ovf output.
module hyper_cordic_iter
  import hyper_cordic_iter_pkg::*;
#(
  parameter int INT_WIDTH = I_INT_WIDTH,
  parameter int FRA_WIDTH = I_FRA_WIDTH,
  parameter int DWIDTH    = 1 + INT_WIDTH + FRA_WIDTH,
  parameter int N_ITER    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] x_in,
  input  logic [DWIDTH-1:0] y_in,
  input  logic [DWIDTH-1:0] z_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] x_out,
  output logic [DWIDTH-1:0] y_out,
  output logic [DWIDTH-1:0] z_out,
  output logic              busy
`ifdef HYPER_CORDIC_SAT_EN
  ,
  output logic              ovf
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITER);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic              rep_q, rep_d;
  logic [DWIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic [DWIDTH-1:0] lut_s, x_rot_s, y_rot_s, z_rot_s;
`ifdef HYPER_CORDIC_SAT_EN
  logic              ovf_q, ovf_d, rot_ovf_s;
`endif

  always_comb begin
    lut_s = '0;
    if ((i_q >= IDX_FIRST) && (i_q <= IDX_MAX)) begin
      lut_s = DWIDTH'(ATANH_LUT[i_q]);
    end else begin
      lut_s = '0;
    end
  end

  hyper_cordic_microrot #(.DWIDTH(DWIDTH)) u_microrot (
    .x     (x_q),
    .y     (y_q),
    .z     (z_q),
    .idx   (i_q),
    .lut   (lut_s),
    .x_nxt (x_rot_s),
    .y_nxt (y_rot_s),
    .z_nxt (z_rot_s)
`ifdef HYPER_CORDIC_SAT_EN
    ,
    .ovf   (rot_ovf_s)
`endif
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    rep_d   = rep_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
`ifdef HYPER_CORDIC_SAT_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          i_d     = IDX_FIRST;
          rep_d   = 1'b0;
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
`ifdef HYPER_CORDIC_SAT_EN
          ovf_d   = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        x_d = x_rot_s;
        y_d = y_rot_s;
        z_d = z_rot_s;
`ifdef HYPER_CORDIC_SAT_EN
        ovf_d = ovf_q | rot_ovf_s;
`endif
        // a repeat index runs once more with rep set before the index advances or the run ends
        if (is_rep_idx(i_q) && !rep_q) begin
          rep_d = 1'b1;
        end else if (i_q == LAST_IDX) begin
          rep_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          rep_d = 1'b0;
          i_d   = i_q + 6'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      i_q         <= IDX_FIRST;
      rep_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef HYPER_CORDIC_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      rep_q       <= rep_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef HYPER_CORDIC_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;
`ifdef HYPER_CORDIC_SAT_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_hyper_cordic_iter.sv
// Directed bench for hyper_cordic_iter: reset, latency, repeat sequencing, backpressure,
// mid-run reset and overflow behaviour, checked against an integer reference model.
module tb_hyper_cordic_iter;

  localparam int     DW   = 21;
  localparam int     NIT  = 16;
  localparam longint MAXV = 64'sd1048575;
  localparam longint MINV = -64'sd1048576;

  logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [DW-1:0] x_in, y_in, z_in, x_out, y_out, z_out;
`ifdef HYPER_CORDIC_SAT_EN
  logic          ovf;
  localparam bit MODEL_SAT = 1'b1;
`else
  localparam bit MODEL_SAT = 1'b0;
`endif

  int            tests_run;
  int            tests_failed;
  longint        lut_q16 [0:63];
  int            seq [$];
  logic [DW-1:0] ztr [$];

  hyper_cordic_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .busy      (busy)
`ifdef HYPER_CORDIC_SAT_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // atanh by power series so the last rounding is exact even for tiny arguments
  function automatic longint atanh_q16(input int i);
    real t, p, s;
    t = 1.0;
    for (int k = 0; k < i; k++) t = t / 2.0;
    p = t;
    s = 0.0;
    for (int k = 0; k < 12; k++) begin
      s = s + p / (2.0 * k + 1.0);
      p = p * t * t;
    end
    return longint'($rtoi(s * 65536.0 + 0.5));
  endfunction

  function automatic longint sx(input logic [DW-1:0] v);
    logic signed [DW-1:0] s;
    s = v;
    return longint'(s);
  endfunction

  function automatic longint fit(input longint v, input bit sat);
    logic [DW-1:0] w;
    if (sat && v > MAXV) return MAXV;
    if (sat && v < MINV) return MINV;
    w = v[DW-1:0];
    return sx(w);
  endfunction

  task automatic run_model(input logic [DW-1:0] xi, yi, zi,
                           output logic [DW-1:0] xo, yo, zo, output bit ov);
    longint x, y, z, nx, ny, nz, d;
    x = sx(xi); y = sx(yi); z = sx(zi); ov = 1'b0;
    seq.delete();
    ztr.delete();
    for (int i = 3; i <= NIT; i++) begin
      for (int r = 0; r < ((i == 4 || i == 13) ? 2 : 1); r++) begin
        seq.push_back(i);
        ztr.push_back(z[DW-1:0]);
        d  = (z >= 0) ? 64'sd1 : -64'sd1;
        nx = x + d * (y >>> i);
        ny = y + d * (x >>> i);
        nz = z - d * lut_q16[i];
        if (nx > MAXV || nx < MINV || ny > MAXV || ny < MINV || nz > MAXV || nz < MINV) ov = 1'b1;
        x = fit(nx, MODEL_SAT);
        y = fit(ny, MODEL_SAT);
        z = fit(nz, MODEL_SAT);
      end
    end
    xo = x[DW-1:0]; yo = y[DW-1:0]; zo = z[DW-1:0];
  endtask

  task automatic send(input logic [DW-1:0] xi, yi, zi);
    in_valid = 1'b1; x_in = xi; y_in = yi; z_in = zi;
    tick();
    in_valid = 1'b0;
  endtask

  // cycle count: presentation cycle is 0, the cycle after the accept edge is 1
  task automatic wait_done(output int cyc, output int rdy_hi);
    cyc = 1; rdy_hi = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (in_ready !== 1'b0) rdy_hi++;
      tick();
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [DW-1:0] ex, ey, ez);
    check_eq({tag, "_x"}, x_out, ex);
    check_eq({tag, "_y"}, y_out, ey);
    check_eq({tag, "_z"}, z_out, ez);
  endtask

  initial begin
    logic [DW-1:0] ex, ey, ez, hx, hy, hz;
    bit            eov;
    int            lat, rdy_hi, bad;
    longint        zs;

    tests_run = 0; tests_failed = 0;
    for (int i = 0; i < 64; i++) lut_q16[i] = (i == 0) ? 64'sd0 : atanh_q16(i);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;

    repeat (2) tick();
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_outputs", {x_out, y_out, z_out}, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // single transaction: 1.0, 0, 0.25
    out_ready = 1'b1;
    run_model(21'h10000, 21'h0, 21'h04000, ex, ey, ez, eov);
    send(21'h10000, 21'h0, 21'h04000);
    check_eq("t1_busy", busy, 1);
    wait_done(lat, rdy_hi);
    check_eq("t1_latency", lat, 17);
    check_eq("t1_in_ready_low", rdy_hi, 0);
    check_result("t1", ex, ey, ez);
    zs = sx(z_out);
    check_eq("t1_z_le_2lsb", ((zs <= 2) && (zs >= -2)) ? 1 : 0, 1);
    tick();
    check_eq("t1_in_ready_next", in_ready, 1);
    check_eq("t1_out_valid_drop", out_valid, 0);

    // repeat sequencing and per-step z trace
    run_model(21'h10000, 21'h0, 21'h00800, ex, ey, ez, eov);
    send(21'h10000, 21'h0, 21'h00800);
    for (int k = 0; k < seq.size(); k++) begin
      check_eq($sformatf("rep_idx%0d", k), dut.i_q, seq[k]);
      check_eq($sformatf("rep_z%0d", k), dut.z_q, ztr[k]);
      tick();
    end
    check_eq("rep_out_valid", out_valid, 1);
    check_result("rep", ex, ey, ez);
    tick();

    // backpressure: hold out_ready low for 10 cycles with a competing in_valid
    out_ready = 1'b0;
    run_model(21'h08000, 21'h02000, 21'h1FC000, ex, ey, ez, eov);
    send(21'h08000, 21'h02000, 21'h1FC000);
    wait_done(lat, rdy_hi);
    check_eq("bp_latency", lat, 17);
    check_result("bp", ex, ey, ez);
    hx = x_out; hy = y_out; hz = z_out;
    in_valid = 1'b1; x_in = 21'h01234; y_in = 21'h05678; z_in = 21'h00100;
    bad = 0;
    repeat (10) begin
      tick();
      if (x_out !== hx || y_out !== hy || z_out !== hz || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check_eq("bp_hold_cycles_bad", bad, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("bp_in_ready_after_hs", in_ready, 1);
    check_eq("bp_out_valid_after_hs", out_valid, 0);
    check_eq("bp_ignored_input", x_out, ex);

    // mid-run reset at RUN cycle 7
    send(21'h10000, 21'h0, 21'h04000);
    repeat (6) tick();
    check_eq("mr_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_in_ready", in_ready, 1);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_out_valid", out_valid, 0);
    check_eq("mr_outputs", {x_out, y_out, z_out}, 0);
    bad = 0;
    repeat (3) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    check_eq("mr_no_out_valid", bad, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    run_model(21'h0C000, 21'h01000, 21'h02000, ex, ey, ez, eov);
    send(21'h0C000, 21'h01000, 21'h02000);
    wait_done(lat, rdy_hi);
    check_eq("mr_new_latency", lat, 17);
    check_result("mr_new", ex, ey, ez);
    tick();

    // most-positive x and y: wraps by default, saturates with the option
    run_model(21'h0FFFFF, 21'h0FFFFF, 21'h04000, ex, ey, ez, eov);
    send(21'h0FFFFF, 21'h0FFFFF, 21'h04000);
    wait_done(lat, rdy_hi);
    check_eq("sat_latency", lat, 17);
    check_result("sat", ex, ey, ez);
`ifdef HYPER_CORDIC_SAT_EN
    check_eq("sat_ovf", ovf, 1);
    tick();
    send(21'h10000, 21'h0, 21'h04000);
    check_eq("sat_ovf_cleared", ovf, 0);
    wait_done(lat, rdy_hi);
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
